// File: rtl/ripple_cap_pkg.sv
// Shared constants and the wrap-aware delta helper for the ripple counter capture block.
package ripple_cap_pkg;

    localparam int DEF_IN_W        = 4;
    localparam int DEF_ACC_W       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Upstream counter held in reset presents all-ones, so the capture side starts there too.
    localparam logic [31:0] SYNC_RST_ALL = '1;

    function automatic logic [31:0] cnt_delta(input logic [31:0] prev,
                                              input logic [31:0] cur,
                                              input int          w,
                                              input bit          down);
        logic [31:0] diff;
        logic [31:0] mask;
        diff = down ? (prev - cur) : (cur - prev);
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return diff & mask;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-bit flop-chain synchronizer with a configurable reset value per bit.
module cdc_sync
    import ripple_cap_pkg::*;
#(
    parameter int             W       = DEF_IN_W,
    parameter int             STAGES  = DEF_SYNC_STAGES,
    parameter logic [W-1:0]   RST_VAL = SYNC_RST_ALL[W-1:0]
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
        end else begin
            chain[0] <= d;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ripple_count_capture.sv
// Samples an asynchronous ripple counter, accumulates its advance into a wide total and
// serves snapshots over valid/ready. Optional glitch filter: define RIPPLE_CAP_FILTER_EN.
module ripple_count_capture
    import ripple_cap_pkg::*;
#(
    parameter int IN_W        = DEF_IN_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_DOWN    = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IN_W-1:0]  cnt_in,
    input  logic             clr,
    input  logic             snap_req,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [ACC_W-1:0] snap_data,
    output logic             acc_ovf
);

    logic [IN_W-1:0]  sync_p0;
    logic [IN_W-1:0]  prev_stable;
    logic [IN_W-1:0]  delta_raw;
    logic [IN_W-1:0]  delta;
    logic             accept;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W:0]   sum;
    logic             load;

    cdc_sync #(
        .W       (IN_W),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SYNC_RST_ALL[IN_W-1:0])
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (cnt_in),
        .q    (sync_p0)
    );

    // ---- stage p1: stability filter (value must repeat on consecutive cycles)
`ifdef RIPPLE_CAP_FILTER_EN
    logic [IN_W-1:0] sync_p1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync_p1 <= SYNC_RST_ALL[IN_W-1:0];
        else       sync_p1 <= sync_p0;
    end

    assign accept = (sync_p0 == sync_p1);
`else
    assign accept = 1'b1;
`endif

    assign delta_raw = IN_W'(cnt_delta(32'(prev_stable), 32'(sync_p0), IN_W, CNT_DOWN != 0));
    assign delta     = accept ? delta_raw : '0;
    assign sum       = {1'b0, acc_q} + (ACC_W+1)'(delta);

    // ---- stage p2: accumulate; clr restarts from the current delta so no events are lost
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_stable <= SYNC_RST_ALL[IN_W-1:0];
            acc_q       <= '0;
            acc_ovf     <= 1'b0;
        end else begin
            if (accept) prev_stable <= sync_p0;
            if (clr) begin
                acc_q   <= ACC_W'(delta);
                acc_ovf <= 1'b0;
            end else begin
                acc_q <= sum[ACC_W-1:0];
                if (sum[ACC_W]) acc_ovf <= 1'b1;
            end
        end
    end

    // ---- snapshot register: captures acc_q before this edge's update
    assign load = snap_req && (!snap_valid || snap_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_valid <= 1'b0;
            snap_data  <= '0;
        end else if (load) begin
            snap_valid <= 1'b1;
            snap_data  <= acc_q;
        end else if (snap_valid && snap_ready) begin
            snap_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture; expectations adapt to RIPPLE_CAP_FILTER_EN.
module tb_ripple_count_capture;

`ifdef RIPPLE_CAP_FILTER_EN
    localparam int    LAT         = 4;
    localparam int    GLITCH_ADV  = 1;
`else
    localparam int    LAT         = 3;
    localparam int    GLITCH_ADV  = 17;  // C->5 gives 7, 5->B gives 10
`endif

    logic        clk;
    logic        rstn;
    logic [3:0]  cnt_in;
    logic        clr;
    logic        snap_req;
    logic        snap_valid;
    logic        snap_ready;
    logic [15:0] snap_data;
    logic        acc_ovf;

    int checks;
    int errors;
    logic [3:0]  cur;
    logic [15:0] acc_exp;

    ripple_count_capture #(
        .IN_W(4), .ACC_W(16), .SYNC_STAGES(2), .CNT_DOWN(1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cnt_in     (cnt_in),
        .clr        (clr),
        .snap_req   (snap_req),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_data  (snap_data),
        .acc_ovf    (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_down(input logic [3:0] d, input int hold);
        cur    = cur - d;
        cnt_in = cur;
        tick(hold);
    endtask

    task automatic take_snap(input string tag, input logic [15:0] exp);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk({tag, "_vld"}, 32'(snap_valid), 32'd1);
        chk({tag, "_data"}, 32'(snap_data), 32'(exp));
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        chk({tag, "_drop"}, 32'(snap_valid), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0; clr = 1'b0; snap_req = 1'b0; snap_ready = 1'b0;
        cur = 4'hF; cnt_in = cur;
        tick(3);
        chk("rst_vld", 32'(snap_valid), 32'd0);
        chk("rst_data", 32'(snap_data), 32'd0);
        chk("rst_ovf", 32'(acc_ovf), 32'd0);
        rstn = 1'b1;

        // idle at the upstream reset value: no spurious delta
        tick(20);
        chk("idle_vld", 32'(snap_valid), 32'd0);
        chk("idle_ovf", 32'(acc_ovf), 32'd0);
        take_snap("idle", 16'd0);

        // F -> E -> D -> C counting down
        step_down(4'd1, 5);
        step_down(4'd1, 5);
        step_down(4'd1, 5);
        tick(5);
        acc_exp = 16'd3;
        take_snap("steps", acc_exp);

        // one-cycle glitch between C and B
        cnt_in = 4'h5;
        tick();
        cur = 4'hB; cnt_in = cur;
        tick(8);
        acc_exp = acc_exp + 16'(GLITCH_ADV);
        take_snap("glitch", acc_exp);

        // clear, then advance to 0xFFFE = 15*4368 + 14
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 4368; i++) step_down(4'd15, 3);
        step_down(4'd14, 3);
        tick(4);
        chk("pre_wrap_ovf", 32'(acc_ovf), 32'd0);
        take_snap("pre_wrap", 16'hFFFE);
        step_down(4'd3, 6);
        chk("wrap_ovf", 32'(acc_ovf), 32'd1);
        take_snap("wrap", 16'h0001);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clr_ovf", 32'(acc_ovf), 32'd0);
        take_snap("clr", 16'd0);

        // held snapshot, ignored request, request together with acceptance
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        chk("hold_vld0", 32'(snap_valid), 32'd1);
        chk("hold_data0", 32'(snap_data), 32'd0);
        step_down(4'd2, 10);
        chk("hold_vld1", 32'(snap_valid), 32'd1);
        chk("hold_data1", 32'(snap_data), 32'd0);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        chk("ign_vld", 32'(snap_valid), 32'd1);
        chk("ign_data", 32'(snap_data), 32'd0);
        snap_req = 1'b1; snap_ready = 1'b1; tick(); snap_req = 1'b0;
        chk("reload_vld", 32'(snap_valid), 32'd1);
        chk("reload_data", 32'(snap_data), 32'd2);
        tick(); snap_ready = 1'b0;
        chk("reload_drop", 32'(snap_valid), 32'd0);

        // clr in the same cycle the delta of 2 commits
        cur = cur - 4'd2; cnt_in = cur;
        tick(LAT - 1);
        clr = 1'b1; tick(); clr = 1'b0;
        tick(4);
        chk("clr_delta_ovf", 32'(acc_ovf), 32'd0);
        take_snap("clr_delta", 16'd2);

        // reset with a snapshot pending
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        chk("pend_vld", 32'(snap_valid), 32'd1);
        chk("pend_data", 32'(snap_data), 32'd2);
        rstn = 1'b0;
        #1;
        chk("arst_vld", 32'(snap_valid), 32'd0);
        chk("arst_data", 32'(snap_data), 32'd0);
        chk("arst_ovf", 32'(acc_ovf), 32'd0);
        cur = 4'hF; cnt_in = cur;
        tick(2);
        rstn = 1'b1;
        tick(6);
        take_snap("post_rst", 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Downstream consumer of the 4-bit ripple counter: samples the counter's asynchronously settling output into the system clock domain, rejects mid-ripple transitional values, and accumulates the observed advance into a wide, wrap-free event total. The total is delivered as on-demand snapshots over a valid/ready handshake, so low-power blocks can read a long event count while only a tiny ripple counter toggles at the event rate.

## Interface

- IN_W, 4: width of the ripple counter value.
- ACC_W, 16: accumulator and snapshot width; must satisfy ACC_W > IN_W.
- SYNC_STAGES, 2: synchronizer depth per input bit; minimum 2.
- CNT_DOWN, 1: 1 means the input value decrements per event (inverted-output counter presentation); 0 means it increments.

- clk  in  1  system clock; the only clock.
- rstn  in  1  reset, asynchronous, active-low.
- cnt_in  in  IN_W  ripple counter output, asynchronous to clk.
- clr  in  1  synchronous clear of the accumulator and overflow flag.
- snap_req  in  1  single-cycle request to capture the accumulator.
- snap_valid  out  1  snapshot available.
- snap_ready  in  1  consumer accepts the snapshot.
- snap_data  out  ACC_W  captured accumulator value.
- acc_ovf  out  1  sticky flag: the accumulator wrapped.

## Operation

- Synchronizer: cnt_in passes through SYNC_STAGES flops per bit. Flops reset to all-ones, which matches the upstream reset value (counter held at 0 presents 4'hF).
- Stability filter: a synced value is accepted only when it equals the synced value from the previous cycle. Accepted values go to prev_stable, which resets to all-ones.
- Delta: on acceptance, delta = (prev_stable − new) mod 2^IN_W when CNT_DOWN=1, or (new − prev_stable) mod 2^IN_W when CNT_DOWN=0. A zero delta leaves the accumulator unchanged.
- Accumulate: acc_q ← acc_q + zero-extended delta, mod 2^ACC_W. A carry out of ACC_W sets acc_ovf, which stays set until clr or reset.
- Aliasing limit: each accepted sample must reflect fewer than 2^IN_W events. An advance of 2^IN_W or more aliases silently; this is a documented limitation, not a detected error.
- clr: acc_q ← 0 and acc_ovf ← 0. prev_stable is not changed, so counting continues seamlessly.
  - If clr and a nonzero delta occur in the same cycle, acc_q ← delta; the delta is not lost.
- Snapshot handshake:
  - snap_req while snap_valid=0: snap_data ← acc_q as registered before this edge's update, and snap_valid ← 1.
  - snap_valid=1: snap_data is held stable until a cycle where snap_valid && snap_ready; snap_valid then drops.
  - snap_req while a snapshot is pending and not accepted in that cycle: ignored.
  - snap_req in the same cycle as acceptance: a new snapshot loads and snap_valid stays 1.
  - clr does not alter a pending snapshot.
- Reset values: snap_valid=0, snap_data=0, acc_ovf=0, acc_q=0.

## Timing

- cnt_in change to synced value: SYNC_STAGES edges. Acceptance: +1 edge (filter). acc_q update: +1 edge. Total with defaults: 4 edges from a stable input change to acc_q.
- snap_req at edge n → snap_valid and snap_data visible after edge n. The value excludes any delta committed at edge n.
- Accept-to-next-load throughput: one snapshot per cycle when snap_req and snap_ready are both held high.
- Reset asserted mid-operation clears all state immediately. The pending snapshot is discarded and the synchronizers return to all-ones. No delta is generated against the upstream counter's own reset value.

## Configuration

- RIPPLE_CAP_FILTER_EN defined: the stability filter is present as described above.
- RIPPLE_CAP_FILTER_EN undefined: the filter is removed and every synced value is accepted every cycle. Acceptance latency drops to 0, so total latency is SYNC_STAGES + 1 edges. Use this only when the upstream counter is guaranteed glitch-free at the sampling point.

## Structure

- Package ripple_cap_pkg holds:
  - default constants for IN_W, ACC_W and SYNC_STAGES;
  - the reset value of the synchronizers and prev_stable (all-ones);
  - a function computing the mod-2^IN_W delta given the direction.
- Sub-module cdc_sync: a parameterized SYNC_STAGES-deep multi-bit synchronizer with a per-bit reset value, instantiated once for cnt_in.

## Test plan

- Reset, then hold cnt_in=4'hF for 20 cycles → acc_q=0, snap_valid=0, acc_ovf=0; a snap_req returns snap_data=0.
- Step cnt_in F→E→D→C (CNT_DOWN=1), each held 5 cycles → acc_q=3 four edges after the last step; the snapshot equals 3.
- Inject a one-cycle glitch value 4'h5 between stable values 4'hC and 4'hB → acc_q advances by exactly 1 with RIPPLE_CAP_FILTER_EN defined.
- Preload the accumulator to 16'hFFFE via repeated wraps, then apply a delta of 3 → acc_q=16'h0001 and acc_ovf=1; clr → acc_q=0, acc_ovf=0.
- Take a snapshot with snap_ready=0 for 10 cycles while the count advances → snap_data is held. Issue a second snap_req during the hold → it is ignored. Assert snap_ready together with snap_req → a new snapshot loads and snap_valid stays 1.
- Assert clr in the same cycle as a delta of 2 → acc_q=2. Assert rstn low while snap_valid=1 → snap_valid=0 and snap_data=0 immediately.
